// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central hazard/stall controller for the 5-stage 16-bit pipeline.
// Produces the PC and pipeline-register write enables together with the
// IF_ID flush and ID_EX bubble controls. It resolves load-use hazards,
// I-/D-cache miss stalls, taken-branch redirects and the HLT drain. It also
// keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   ID_src1/2, ID_use_src1/2     source registers of the ID instruction
//   EX_MemRead, EX_dst_reg       load flag and destination of the EX instruction
//   br_taken, ID_halt            branch-taken redirect and HLT decode in ID
//   icache_stall, dcache_stall   memory not ready
//   *_wen, if_id_flush,
//   id_ex_bubble                 pipeline controls (combinational, same edge)
//   halted, stall_cnt            halt status and stall-cycle count
//
// state  | meaning
// RUN    | normal operation, hazard priority resolution
// DRAIN  | HLT accepted; older instructions retire, fetch and decode held
// HALTED | processor stopped; only reset exits
module pipe_stall_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ID_src1,
    input  logic [3:0]       ID_src2,
    input  logic             ID_use_src1,
    input  logic             ID_use_src2,
    input  logic             EX_MemRead,
    input  logic [3:0]       EX_dst_reg,
    input  logic             br_taken,
    input  logic             ID_halt,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             id_ex_wen,
    output logic             ex_mem_wen,
    output logic             mem_wb_wen,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [2:0] DRAIN_MAX = 3'(DRAIN_CYCLES);

    state_t           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic [4:0] wen_c;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic       flush_c;
    logic       bubble_c;
    logic       stall_evt;

    assign load_use = EX_MemRead && (EX_dst_reg != 4'd0) &&
                      ((ID_use_src1 && (ID_src1 == EX_dst_reg)) ||
                       (ID_use_src2 && (ID_src2 == EX_dst_reg)));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        wen_c     = 5'b00000;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        stall_evt = 1'b0;
        case (state_q)
            RUN: begin
                if (dcache_stall) begin
                    stall_evt = 1'b1;
                end else if (load_use) begin
                    wen_c     = 5'b00111;
                    bubble_c  = 1'b1;
                    stall_evt = 1'b1;
                end else if (br_taken) begin
                    // Redirect wins over an I-cache miss so the target PC loads.
                    wen_c   = 5'b11111;
                    flush_c = 1'b1;
                end else if (icache_stall) begin
                    wen_c     = 5'b01111;
                    flush_c   = 1'b1;
                    stall_evt = 1'b1;
                end else if (ID_halt) begin
                    wen_c    = 5'b00111;
                    bubble_c = 1'b1;
                    state_d  = DRAIN;
                    drain_d  = 3'd0;
                end else begin
                    wen_c = 5'b11111;
                end
            end
            DRAIN: begin
                if (dcache_stall) begin
                    stall_evt = 1'b1;
                end else begin
                    wen_c    = 5'b00111;
                    bubble_c = 1'b1;
                    if (drain_q == DRAIN_MAX) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        cnt_d = cnt_q;
        if (stall_evt && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are forced inactive while reset is asserted, without waiting
    // for an edge.
    assign pc_wen       = wen_c[4] & rst_n;
    assign if_id_wen    = wen_c[3] & rst_n;
    assign id_ex_wen    = wen_c[2] & rst_n;
    assign ex_mem_wen   = wen_c[1] & rst_n;
    assign mem_wb_wen   = wen_c[0] & rst_n;
    assign if_id_flush  = flush_c  & rst_n;
    assign id_ex_bubble = bubble_c & rst_n;
    assign halted       = (state_q == HALTED) & rst_n;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       ID_src1, ID_src2, EX_dst_reg;
    logic             ID_use_src1, ID_use_src2, EX_MemRead;
    logic             br_taken, ID_halt, icache_stall, dcache_stall;
    logic             pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
    logic             if_id_flush, id_ex_bubble, halted;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_src1(ID_src1), .ID_src2(ID_src2),
        .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2),
        .EX_MemRead(EX_MemRead), .EX_dst_reg(EX_dst_reg),
        .br_taken(br_taken), .ID_halt(ID_halt),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
        .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks {pc,if_id,id_ex,ex_mem,mem_wb}, flush, bubble, halted after settling.
    task automatic chk_out(input string tag, input logic [4:0] wen,
                           input logic fl, input logic bu, input logic ha);
        #1;
        chk({tag, ".wen"}, {27'd0, pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen}, {27'd0, wen});
        chk({tag, ".flush"}, {31'd0, if_id_flush}, {31'd0, fl});
        chk({tag, ".bubble"}, {31'd0, id_ex_bubble}, {31'd0, bu});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, ha});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ID_src1 = 4'd1; ID_src2 = 4'd2; ID_use_src1 = 1'b0; ID_use_src2 = 1'b0;
        EX_MemRead = 1'b0; EX_dst_reg = 4'd0; br_taken = 1'b0; ID_halt = 1'b0;
        icache_stall = 1'b0; dcache_stall = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        chk_out("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("reset.cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        chk_out("idle", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Load-use on src2 = r5
        EX_MemRead = 1'b1; EX_dst_reg = 4'd5; ID_src2 = 4'd5; ID_use_src2 = 1'b1;
        chk_out("lu", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu.cnt", 32'(stall_cnt), 32'd1);
        EX_dst_reg = 4'd0; ID_src2 = 4'd0;
        chk_out("lu_r0", 5'b11111, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lu_r0.cnt", 32'(stall_cnt), 32'd1);

        // Load-use on src1, but ID does not read it -> no hazard
        EX_dst_reg = 4'd7; ID_src1 = 4'd7; ID_use_src1 = 1'b0; ID_src2 = 4'd3;
        chk_out("lu_nouse", 5'b11111, 1'b0, 1'b0, 1'b0);
        ID_use_src1 = 1'b1;
        chk_out("lu_src1", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu_src1.cnt", 32'(stall_cnt), 32'd2);

        // dcache freeze over load_use and br_taken, 3 cycles
        br_taken = 1'b1; dcache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_out("dc_freeze", 5'b00000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("dc.cnt", 32'(stall_cnt), 32'd5);
        dcache_stall = 1'b0;
        chk_out("dc_then_lu", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        chk("dc_then_lu.cnt", 32'(stall_cnt), 32'd6);

        // Branch over icache miss
        EX_MemRead = 1'b0; icache_stall = 1'b1;
        chk_out("br_ic", 5'b11111, 1'b1, 1'b0, 1'b0);
        tick();
        chk("br_ic.cnt", 32'(stall_cnt), 32'd6);
        br_taken = 1'b0;
        chk_out("ic", 5'b01111, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ic.cnt", 32'(stall_cnt), 32'd7);

        // Halt masked by icache miss stays pending
        ID_halt = 1'b1;
        chk_out("halt_masked", 5'b01111, 1'b1, 1'b0, 1'b0);
        tick();
        chk("halt_masked.cnt", 32'(stall_cnt), 32'd8);
        icache_stall = 1'b0;
        chk_out("halt_accept", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();  // accept edge
        ID_halt = 1'b0;
        dcache_stall = 1'b1;
        chk_out("drain_frz", 5'b00000, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                dcache_stall = 1'b0;
                br_taken = 1'b1; icache_stall = 1'b1;
                EX_MemRead = 1'b1; EX_dst_reg = 4'd4; ID_src1 = 4'd4; ID_use_src1 = 1'b1;
            end
            if (k < 6) chk_out("drain", 5'b00111, 1'b0, 1'b1, 1'b0);
            else       chk_out("halted", 5'b00000, 1'b0, 1'b0, 1'b1);
        end
        chk("drain.cnt", 32'(stall_cnt), 32'd9);
        dcache_stall = 1'b1; ID_halt = 1'b1;
        tick();
        dcache_stall = 1'b0;
        tick();
        chk_out("halted_hold", 5'b00000, 1'b0, 1'b0, 1'b1);
        chk("halted.cnt", 32'(stall_cnt), 32'd9);

        // Reset mid-DRAIN
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        ID_halt = 1'b1;
        tick();
        ID_halt = 1'b0;
        chk_out("drain2", 5'b00111, 1'b0, 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        chk_out("rst_drain", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("rst_drain.cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        chk_out("post_rst", 5'b11111, 1'b0, 1'b0, 1'b0);

        // Saturation
        icache_stall = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat.full", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("sat.nowrap", 32'(stall_cnt), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard and stall controller for the 5-stage 16-bit pipeline.
- Drives the write-enable inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the flush/bubble controls.
- Resolves load-use hazards, I-/D-cache miss stalls, taken-branch flushes and HLT drain.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- DRAIN_CYCLES, 4: cycles the pipeline keeps running after HLT is accepted, so older instructions retire before the halt.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_src1  in  4  source register 1 of the instruction in ID.
- ID_src2  in  4  source register 2 of the instruction in ID.
- ID_use_src1  in  1  the ID instruction reads ID_src1.
- ID_use_src2  in  1  the ID instruction reads ID_src2.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_dst_reg  in  4  destination register of the instruction in EX.
- br_taken  in  1  branch resolved taken in ID this cycle.
- ID_halt  in  1  HLT decoded in ID.
- icache_stall  in  1  instruction fetch not ready.
- dcache_stall  in  1  data memory access not complete.
- pc_wen  out  1  PC update enable.
- if_id_wen  out  1  IF_ID write enable.
- id_ex_wen  out  1  ID_EX write enable.
- ex_mem_wen  out  1  EX_MEM write enable.
- mem_wb_wen  out  1  MEM_WB write enable.
- if_id_flush  out  1  load a NOP into IF_ID on this edge.
- id_ex_bubble  out  1  load a NOP (all control bits 0) into ID_EX on this edge.
- halted  out  1  processor halted.
- stall_cnt  out  CNT_W  stall-cycle count.

Behaviour:
- State register: RUN, DRAIN, HALTED. Drain counter: 3 bits, sized to DRAIN_CYCLES.
- On rst_n low (asynchronous):
  - state=RUN, drain counter=0, stall_cnt=0.
  - All wen, if_id_flush and id_ex_bubble forced to 0; halted=0.
- All wen/flush/bubble outputs are combinational from the current state and inputs, and take effect on the same edge (zero latency).
- load_use = EX_MemRead & EX_dst_reg!=0 & ((ID_use_src1 & ID_src1==EX_dst_reg) | (ID_use_src2 & ID_src2==EX_dst_reg)). Register 0 never causes a hazard.
- RUN priority, highest first:
  1. dcache_stall: all five wen=0, flush=0, bubble=0 (full freeze).
  2. load_use: pc_wen=0, if_id_wen=0, id_ex_bubble=1, id_ex/ex_mem/mem_wb wen=1.
  3. br_taken: all wen=1, if_id_flush=1. This overrides icache_stall, so the redirect PC is loaded.
  4. icache_stall: pc_wen=0, if_id_flush=1 (NOP into ID), remaining wen=1.
  5. ID_halt: pc_wen=0, if_id_wen=0, id_ex_bubble=1, others=1; next state=DRAIN, drain counter=0.
  6. Otherwise: all wen=1, flush=0, bubble=0.
- ID_halt is accepted only when case 5 is reached. A halt masked by cases 1-4 stays pending until the stall clears.
- DRAIN:
  - pc_wen=0, if_id_wen=0, id_ex_bubble=1, other wen=1.
  - dcache_stall freezes all wen and pauses the drain counter.
  - The counter increments on each non-frozen cycle. After DRAIN_CYCLES increments, next state=HALTED.
  - br_taken, icache_stall and load_use are ignored.
- HALTED: all wen=0, flush=0, bubble=0, halted=1. Only reset exits.
- stall_cnt:
  - Increments by 1 each cycle in RUN or DRAIN where dcache_stall, load_use or icache_stall is active (as evaluated under the priority above; br_taken cycles do not count).
  - Saturates at all-ones; no wrap.
  - Holds in HALTED.

Test Plan:
- Reset: rst_n=0 mid-DRAIN -> all wen=0, halted=0, stall_cnt=0 immediately with no clock edge. After release with idle inputs -> all wen=1.
- Load-use: EX_MemRead=1, EX_dst_reg=5, ID_src2=5, ID_use_src2=1 -> one cycle of pc_wen=0, if_id_wen=0, id_ex_bubble=1, stall_cnt 0->1. Repeat with EX_dst_reg=0 -> no stall.
- dcache_stall held 3 cycles while load_use=1 and br_taken=1 -> all wen=0 for 3 cycles, stall_cnt +3. Next cycle, load_use handling applies.
- br_taken=1 and icache_stall=1 together -> pc_wen=1, if_id_flush=1, stall_cnt unchanged.
- ID_halt=1 in RUN, then 1 dcache_stall cycle inside DRAIN -> halted=1 exactly 1+DRAIN_CYCLES+1=6 edges after accept. In HALTED, all wen stay 0 with any inputs.
- Saturation: force 0xFFFF+2 icache_stall cycles (CNT_W=16) -> stall_cnt=0xFFFF, no wrap.
